// File: rtl/rn_axi_bridge.sv
// rtl/rn_axi_bridge.sv - AXI request-node bridge packing AW/W/AR into NoC flits and unpacking B/R
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   AW*/W*/B*/AR*/R*                AXI slave-side channels from the master
//   aw_valid/aw_ready, aw_payload,  NoC AW request flit (registered, one-entry stage)
//     aw_tgtid, aw_srcid
//   w_valid/w_ready, w_head,        NoC W data flits (combinational, ordered behind AW)
//     w_tail, w_payload, w_tgtid, w_srcid
//   b_valid/b_ready, b_payload      NoC B response flit
//   ar_valid/ar_ready, ar_payload,  NoC AR request flit (registered, one-entry stage)
//     ar_tgtid, ar_srcid
//   r_valid/r_ready, r_head,        NoC R response flits
//     r_tail, r_payload

module rn_axi_bridge #(
    parameter logic [1:0] SRC_ID  = 2'd0,
    parameter int         TGT_BIT = 29,
    parameter int         MAX_WR  = 16,
    parameter int         MAX_RD  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [10:0] AWID,
    input  logic [31:0] AWADDR,
    input  logic [7:0]  AWLEN,
    input  logic [2:0]  AWSIZE,
    input  logic [1:0]  AWBURST,
    input  logic        WVALID,
    output logic        WREADY,
    input  logic [63:0] WDATA,
    input  logic [7:0]  WSTRB,
    input  logic        WLAST,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [10:0] BID,
    output logic [1:0]  BRESP,
    input  logic        ARVALID,
    output logic        ARREADY,
    input  logic [10:0] ARID,
    input  logic [31:0] ARADDR,
    input  logic [7:0]  ARLEN,
    input  logic [2:0]  ARSIZE,
    input  logic [1:0]  ARBURST,
    output logic        RVALID,
    input  logic        RREADY,
    output logic [10:0] RID,
    output logic [63:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RLAST,
    output logic        aw_valid,
    input  logic        aw_ready,
    output logic [81:0] aw_payload,
    output logic        aw_tgtid,
    output logic [1:0]  aw_srcid,
    output logic        w_valid,
    input  logic        w_ready,
    output logic        w_head,
    output logic        w_tail,
    output logic [81:0] w_payload,
    output logic        w_tgtid,
    output logic [1:0]  w_srcid,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [81:0] b_payload,
    output logic        ar_valid,
    input  logic        ar_ready,
    output logic [81:0] ar_payload,
    output logic        ar_tgtid,
    output logic [1:0]  ar_srcid,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic        r_head,
    input  logic        r_tail,
    input  logic [81:0] r_payload
);

    localparam int WCW = $clog2(MAX_WR + 1);
    localparam int RCW = $clog2(MAX_RD + 1);
    localparam int PW  = (MAX_WR > 1) ? $clog2(MAX_WR) : 1;
    localparam logic [WCW-1:0] WR_LIMIT = WCW'(MAX_WR);
    localparam logic [RCW-1:0] RD_LIMIT = RCW'(MAX_RD);
    localparam logic [PW-1:0]  PTR_LAST = PW'(MAX_WR - 1);

    logic [WCW-1:0]    wr_cnt;
    logic [RCW-1:0]    rd_cnt;

    logic              aw_full;
    logic [81:0]       aw_payload_q;
    logic              aw_tgtid_q;
    logic              ar_full;
    logic [81:0]       ar_payload_q;
    logic              ar_tgtid_q;

    // AW-info FIFO: one target-id bit per accepted write, consumed by the W path
    logic [MAX_WR-1:0] fifo_mem;
    logic [PW-1:0]     fifo_rd;
    logic [PW-1:0]     fifo_wr;
    logic [WCW-1:0]    fifo_cnt;
    logic              fifo_full;
    logic              fifo_nonempty;

    logic              w_first;

    logic              aw_hs;
    logic              ar_hs;
    logic              w_hs;
    logic              fifo_pop;
    logic              b_hs;
    logic              r_last_hs;

    assign fifo_full     = (fifo_cnt == WR_LIMIT);
    assign fifo_nonempty = (fifo_cnt != '0);

    // Decisions use registered counts, so a drain in the same cycle does not reopen READY
    assign AWREADY = (wr_cnt != WR_LIMIT) && !fifo_full && (!aw_full || aw_ready);
    assign ARREADY = (rd_cnt != RD_LIMIT) && (!ar_full || ar_ready);

    assign aw_hs     = AWVALID && AWREADY;
    assign ar_hs     = ARVALID && ARREADY;
    assign w_hs      = WVALID && WREADY;
    assign fifo_pop  = w_hs && WLAST;
    assign b_hs      = BVALID && BREADY;
    assign r_last_hs = RVALID && RREADY && r_tail;

    assign aw_valid   = aw_full;
    assign aw_payload = aw_payload_q;
    assign aw_tgtid   = aw_tgtid_q;
    assign aw_srcid   = SRC_ID;
    assign ar_valid   = ar_full;
    assign ar_payload = ar_payload_q;
    assign ar_tgtid   = ar_tgtid_q;
    assign ar_srcid   = SRC_ID;

    // W beats are held off until their AW has been recorded in the FIFO
    assign w_valid   = WVALID && fifo_nonempty;
    assign WREADY    = w_ready && fifo_nonempty;
    assign w_head    = w_first;
    assign w_tail    = WLAST;
    assign w_payload = {10'b0, WSTRB, WDATA};
    assign w_tgtid   = fifo_mem[fifo_rd];
    assign w_srcid   = SRC_ID;

    assign BVALID  = b_valid;
    assign b_ready = BREADY;
    assign BID     = b_payload[10:0];
    assign BRESP   = b_payload[12:11];

    assign RVALID  = r_valid;
    assign r_ready = RREADY;
    assign RID     = r_payload[10:0];
    assign RDATA   = r_payload[74:11];
    assign RRESP   = r_payload[76:75];
    assign RLAST   = r_tail;

    logic unused_bits;
    assign unused_bits = ^{b_payload[81:13], r_payload[81:77], r_head};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full      <= 1'b0;
            aw_payload_q <= '0;
            aw_tgtid_q   <= 1'b0;
        end else if (aw_hs) begin
            aw_full      <= 1'b1;
            aw_payload_q <= {22'b0, AWBURST, AWSIZE, AWLEN, 4'b0, AWADDR, AWID};
            aw_tgtid_q   <= AWADDR[TGT_BIT];
        end else if (aw_ready) begin
            aw_full      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_full      <= 1'b0;
            ar_payload_q <= '0;
            ar_tgtid_q   <= 1'b0;
        end else if (ar_hs) begin
            ar_full      <= 1'b1;
            ar_payload_q <= {22'b0, ARBURST, ARSIZE, ARLEN, 4'b0, ARADDR, ARID};
            ar_tgtid_q   <= ARADDR[TGT_BIT];
        end else if (ar_ready) begin
            ar_full      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
        end else if (aw_hs && !b_hs) begin
            wr_cnt <= wr_cnt + 1'b1;
        end else if (b_hs && !aw_hs && (wr_cnt != '0)) begin
            wr_cnt <= wr_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
        end else if (ar_hs && !r_last_hs) begin
            rd_cnt <= rd_cnt + 1'b1;
        end else if (r_last_hs && !ar_hs && (rd_cnt != '0)) begin
            rd_cnt <= rd_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem <= '0;
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (aw_hs) begin
                fifo_mem[fifo_wr] <= AWADDR[TGT_BIT];
                fifo_wr           <= (fifo_wr == PTR_LAST) ? '0 : fifo_wr + 1'b1;
            end
            if (fifo_pop) begin
                fifo_rd <= (fifo_rd == PTR_LAST) ? '0 : fifo_rd + 1'b1;
            end
            if (aw_hs && !fifo_pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (fifo_pop && !aw_hs) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    // Head marker: set at reset and after each burst's last beat, cleared by any beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_first <= 1'b1;
        end else if (w_hs) begin
            w_first <= WLAST;
        end
    end

endmodule

// File: tb/tb_rn_axi_bridge.sv
// tb/tb_rn_axi_bridge.sv - directed self-checking bench for rn_axi_bridge

module tb_rn_axi_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        AWVALID, AWREADY;
    logic [10:0] AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        WVALID, WREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST;
    logic        BVALID, BREADY;
    logic [10:0] BID;
    logic [1:0]  BRESP;
    logic        ARVALID, ARREADY;
    logic [10:0] ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        RVALID, RREADY;
    logic [10:0] RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        aw_valid, aw_ready;
    logic [81:0] aw_payload;
    logic        aw_tgtid;
    logic [1:0]  aw_srcid;
    logic        w_valid, w_ready, w_head, w_tail;
    logic [81:0] w_payload;
    logic        w_tgtid;
    logic [1:0]  w_srcid;
    logic        b_valid, b_ready;
    logic [81:0] b_payload;
    logic        ar_valid, ar_ready;
    logic [81:0] ar_payload;
    logic        ar_tgtid;
    logic [1:0]  ar_srcid;
    logic        r_valid, r_ready, r_head, r_tail;
    logic [81:0] r_payload;

    int errors = 0;
    int checks = 0;

    int          aw_n = 0;
    int          ar_n = 0;
    logic [81:0] w_pl_q[$];
    logic        w_hd_q[$];
    logic        w_tl_q[$];
    logic        w_tg_q[$];

    rn_axi_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
        .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARADDR(ARADDR),
        .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_payload(aw_payload),
        .aw_tgtid(aw_tgtid), .aw_srcid(aw_srcid),
        .w_valid(w_valid), .w_ready(w_ready), .w_head(w_head), .w_tail(w_tail),
        .w_payload(w_payload), .w_tgtid(w_tgtid), .w_srcid(w_srcid),
        .b_valid(b_valid), .b_ready(b_ready), .b_payload(b_payload),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_payload(ar_payload),
        .ar_tgtid(ar_tgtid), .ar_srcid(ar_srcid),
        .r_valid(r_valid), .r_ready(r_ready), .r_head(r_head), .r_tail(r_tail),
        .r_payload(r_payload)
    );

    always #5 clk = ~clk;

    // Flit monitors: a handshake seen at the negedge completes on the following posedge
    always @(negedge clk) begin
        if (rst_n) begin
            if (aw_valid && aw_ready) aw_n = aw_n + 1;
            if (ar_valid && ar_ready) ar_n = ar_n + 1;
            if (w_valid && w_ready) begin
                w_pl_q.push_back(w_payload);
                w_hd_q.push_back(w_head);
                w_tl_q.push_back(w_tail);
                w_tg_q.push_back(w_tgtid);
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [10:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd3; AWBURST = 2'd1;
        @(negedge clk);
        while (!AWREADY && n < 200) begin @(negedge clk); n++; end
        check("aw_handshake", AWREADY, 1'b1);
        cyc();
        AWVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [10:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd3; ARBURST = 2'd1;
        @(negedge clk);
        while (!ARREADY && n < 200) begin @(negedge clk); n++; end
        check("ar_handshake", ARREADY, 1'b1);
        cyc();
        ARVALID = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        WVALID = 1'b1; WDATA = data; WSTRB = strb; WLAST = last;
        @(negedge clk);
        while (!WREADY && n < 200) begin @(negedge clk); n++; end
        check("w_handshake", WREADY, 1'b1);
        cyc();
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic b_ret(input logic [10:0] id, input logic [1:0] resp);
        b_valid = 1'b1; b_payload = {69'b0, resp, id}; BREADY = 1'b1;
        cyc();
        b_valid = 1'b0; BREADY = 1'b0;
    endtask

    task automatic r_ret(input logic [10:0] id, input logic [63:0] data, input logic tail);
        r_valid = 1'b1; r_tail = tail; r_payload = {5'b0, 2'b00, data, id}; RREADY = 1'b1;
        cyc();
        r_valid = 1'b0; r_tail = 1'b0; RREADY = 1'b0;
    endtask

    logic [81:0] exp_pl;
    int          base;

    initial begin
        rst_n = 1'b0;
        AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
        WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; BREADY = 0;
        ARVALID = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; RREADY = 0;
        aw_ready = 0; w_ready = 0; ar_ready = 0;
        b_valid = 0; b_payload = 0; r_valid = 0; r_head = 0; r_tail = 0; r_payload = 0;
        repeat (3) cyc();
        rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_awready", AWREADY, 1'b1);
        check("rst_arready", ARREADY, 1'b1);
        check("rst_wready", WREADY, 1'b0);
        check("rst_aw_valid", aw_valid, 1'b0);
        check("rst_ar_valid", ar_valid, 1'b0);
        check("rst_w_valid", w_valid, 1'b0);
        check("rst_w_head", w_head, 1'b1);

        // Four-beat write to target 1
        aw_ready = 1; w_ready = 1; ar_ready = 1;
        cyc();
        send_aw(11'd5, 32'h2000_1000, 8'd3);
        check("aw1_valid", aw_valid, 1'b1);
        check("aw1_tgtid", aw_tgtid, 1'b1);
        check("aw1_len", aw_payload[54:47], 8'd3);
        check("aw1_id", aw_payload[10:0], 11'd5);
        check("aw1_addr", aw_payload[42:11], 32'h2000_1000);
        check("aw1_size_burst", aw_payload[59:55], {2'd1, 3'd3});
        check("aw1_zero_bits", {aw_payload[81:60], aw_payload[46:43]}, 26'd0);
        check("aw1_srcid", aw_srcid, 2'd0);
        cyc();
        check("aw1_count", aw_n, 1);
        check("aw1_valid_clear", aw_valid, 1'b0);
        for (int i = 0; i < 4; i++) send_w(64'h1000 + i, 8'hF0 + i, i == 3);
        check("w1_beats", w_pl_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("w1_head%0d", i), w_hd_q[i], i == 0);
            check($sformatf("w1_tail%0d", i), w_tl_q[i], i == 3);
            check($sformatf("w1_tgt%0d", i), w_tg_q[i], 1'b1);
            check($sformatf("w1_pl%0d", i), w_pl_q[i], {10'b0, 8'hF0 + 8'(i), 64'h1000 + 64'(i)});
        end
        b_valid = 1'b1; b_payload = {69'b0, 2'b10, 11'd5}; BREADY = 1'b1;
        #1;
        check("b1_bvalid", BVALID, 1'b1);
        check("b1_bid", BID, 11'd5);
        check("b1_bresp", BRESP, 2'b10);
        check("b1_b_ready", b_ready, 1'b1);
        cyc();
        b_valid = 1'b0; BREADY = 1'b0;

        // W arrives 5 cycles before its single-beat AW
        w_pl_q.delete(); w_hd_q.delete(); w_tl_q.delete(); w_tg_q.delete();
        WVALID = 1'b1; WDATA = 64'hABCD; WSTRB = 8'h0F; WLAST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("early_wready%0d", i), WREADY, 1'b0);
            check($sformatf("early_w_valid%0d", i), w_valid, 1'b0);
            cyc();
        end
        AWVALID = 1'b1; AWID = 11'd2; AWADDR = 32'h0000_0800; AWLEN = 8'd0; AWSIZE = 3'd3; AWBURST = 2'd1;
        #1;
        check("early_hs_cycle_wready", WREADY, 1'b0);
        check("early_awready", AWREADY, 1'b1);
        cyc();
        AWVALID = 1'b0;
        #1;
        check("early_after_wready", WREADY, 1'b1);
        check("early_after_w_valid", w_valid, 1'b1);
        check("early_head", w_head, 1'b1);
        check("early_tail", w_tail, 1'b1);
        check("early_tgt", w_tgtid, 1'b0);
        check("early_pl", w_payload, {10'b0, 8'h0F, 64'hABCD});
        cyc();
        WVALID = 1'b0; WLAST = 1'b0;
        #1;
        check("early_beats", w_pl_q.size(), 1);
        check("early_fifo_drained", WREADY, 1'b0);
        b_ret(11'd2, 2'b00);

        // Outstanding-write cap
        base = aw_n;
        for (int i = 0; i < 16; i++) send_aw(11'(i), 32'(i) << 12, 8'd0);
        for (int i = 0; i < 16; i++) send_w(64'(i), 8'hFF, 1'b1);
        AWVALID = 1'b1; AWID = 11'd99; AWADDR = 32'h0; AWLEN = 8'd0;
        #1;
        check("wcap_17th_blocked", AWREADY, 1'b0);
        cyc();
        b_valid = 1'b1; b_payload = {69'b0, 2'b00, 11'd0}; BREADY = 1'b1;
        #1;
        check("wcap_drain_cycle_blocked", AWREADY, 1'b0);
        cyc();
        b_valid = 1'b0; BREADY = 1'b0;
        #1;
        check("wcap_reopen", AWREADY, 1'b1);
        cyc();
        AWVALID = 1'b0;
        send_w(64'h99, 8'hFF, 1'b1);
        for (int i = 0; i < 16; i++) b_ret(11'(i), 2'b00);
        cyc();
        check("wcap_aw_flits", aw_n - base, 17);
        check("wcap_final_ready", AWREADY, 1'b1);

        // Outstanding-read cap
        base = ar_n;
        for (int i = 0; i < 8; i++) send_ar(11'(i), 32'(i) << 8, 8'd0);
        cyc();
        check("rcap_ar_flits", ar_n - base, 8);
        ARVALID = 1'b1; ARID = 11'd9; ARADDR = 32'h2000_0000;
        #1;
        check("rcap_9th_blocked", ARREADY, 1'b0);
        r_valid = 1'b1; r_head = 1'b1; r_tail = 1'b0; RREADY = 1'b1;
        r_payload = {5'b0, 2'b11, 64'hDEAD_BEEF_0123_4567, 11'd3};
        #1;
        check("r_nontail_rlast", RLAST, 1'b0);
        check("r_rvalid", RVALID, 1'b1);
        check("r_rid", RID, 11'd3);
        check("r_rdata", RDATA, 64'hDEAD_BEEF_0123_4567);
        check("r_rresp", RRESP, 2'b11);
        check("r_r_ready", r_ready, 1'b1);
        cyc();
        check("rcap_after_nontail", ARREADY, 1'b0);
        r_head = 1'b0; r_tail = 1'b1;
        #1;
        check("r_tail_rlast", RLAST, 1'b1);
        check("rcap_tail_cycle_blocked", ARREADY, 1'b0);
        cyc();
        r_valid = 1'b0; r_tail = 1'b0; RREADY = 1'b0;
        #1;
        check("rcap_reopen", ARREADY, 1'b1);
        cyc();
        ARVALID = 1'b0;
        #1;
        check("ar9_tgtid", ar_tgtid, 1'b1);
        check("ar9_id", ar_payload[10:0], 11'd9);
        for (int i = 0; i < 8; i++) r_ret(11'(i), 64'(i), 1'b1);
        check("rcap_final_ready", ARREADY, 1'b1);

        // AW flit back-pressure holds payload stable
        aw_ready = 1'b0;
        send_aw(11'd7, 32'h0000_4000, 8'd0);
        exp_pl = {22'b0, 2'd1, 3'd3, 8'd0, 4'b0, 32'h0000_4000, 11'd7};
        base = aw_n;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_valid%0d", i), aw_valid, 1'b1);
            check($sformatf("bp_payload%0d", i), aw_payload, exp_pl);
            check($sformatf("bp_awready%0d", i), AWREADY, 1'b0);
            cyc();
        end
        aw_ready = 1'b1;
        cyc();
        check("bp_one_flit", aw_n - base, 1);
        cyc(); cyc();
        check("bp_no_dup", aw_n - base, 1);
        check("bp_valid_clear", aw_valid, 1'b0);
        send_w(64'h7, 8'hFF, 1'b1);
        b_ret(11'd7, 2'b00);

        // Asynchronous reset in the middle of a burst
        send_aw(11'd9, 32'h2000_0000, 8'd3);
        send_w(64'h20, 8'hFF, 1'b0);
        send_w(64'h21, 8'hFF, 1'b0);
        ar_ready = 1'b0;
        send_ar(11'd1, 32'h0, 8'd0);
        WVALID = 1'b1; WDATA = 64'h22; WSTRB = 8'hFF; WLAST = 1'b0;
        #2;
        check("mid_w_valid", w_valid, 1'b1);
        check("mid_w_head", w_head, 1'b0);
        check("mid_ar_valid", ar_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_w_valid", w_valid, 1'b0);
        check("arst_ar_valid", ar_valid, 1'b0);
        check("arst_aw_valid", aw_valid, 1'b0);
        check("arst_wready", WREADY, 1'b0);
        check("arst_wr_cnt", dut.wr_cnt, 0);
        check("arst_rd_cnt", dut.rd_cnt, 0);
        WVALID = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        ar_ready = 1'b1;
        cyc();
        send_aw(11'd10, 32'h2000_0000, 8'd0);
        WVALID = 1'b1; WDATA = 64'h30; WSTRB = 8'hFF; WLAST = 1'b1;
        #1;
        check("post_rst_w_valid", w_valid, 1'b1);
        check("post_rst_w_head", w_head, 1'b1);
        check("post_rst_w_tgt", w_tgtid, 1'b1);
        cyc();
        WVALID = 1'b0; WLAST = 1'b0;
        b_ret(11'd10, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
